// File: rtl/route_input_buffer_pkg.sv
// Shared definitions for the router input buffer: output port encoding
// and header field positions within a flit.
package route_input_buffer_pkg;

  typedef logic [2:0] port_t;

  localparam port_t PORT_LOCAL = 3'd0;
  localparam port_t PORT_NORTH = 3'd1;
  localparam port_t PORT_EAST  = 3'd2;
  localparam port_t PORT_SOUTH = 3'd3;
  localparam port_t PORT_WEST  = 3'd4;
  localparam port_t PORT_ERR   = 3'd5;

  // Destination coordinates sit at the top of the flit, x above y.
  function automatic int dest_x_msb(input int data_w);
    return data_w - 1;
  endfunction

  function automatic int dest_y_msb(input int data_w, input int coord_w);
    return data_w - 1 - coord_w;
  endfunction

endpackage

// File: rtl/route_input_buffer_xy_route_compute.sv
// Combinational XY dimension-order route for one flit header.
// Destinations outside the mesh go to the error sink port.
module xy_route_compute
  import route_input_buffer_pkg::*;
#(
  parameter int COORD_W  = 2,
  parameter int MESH_DIM = 4
) (
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  output port_t              port
);

  localparam logic [31:0] LIMIT = 32'(MESH_DIM);

  logic out_of_mesh;

  assign out_of_mesh = (32'(dest_x) >= LIMIT) || (32'(dest_y) >= LIMIT);

  always_comb begin
    port = PORT_LOCAL;
    if (out_of_mesh)          port = PORT_ERR;
    else if (dest_x > cur_x)  port = PORT_EAST;
    else if (dest_x < cur_x)  port = PORT_WEST;
    else if (dest_y > cur_y)  port = PORT_SOUTH;
    else if (dest_y < cur_y)  port = PORT_NORTH;
  end

endmodule

// File: rtl/route_input_buffer.sv
// Router input FIFO that computes each flit's XY output port on enqueue.
// Define ROUTE_INPUT_BUFFER_BYPASS_EN for a same-cycle path when empty.
module route_input_buffer
  import route_input_buffer_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int COORD_W  = 2,
  parameter int MESH_DIM = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COORD_W-1:0]       cur_x,
  input  logic [COORD_W-1:0]       cur_y,
  input  logic [DATA_W-1:0]        in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_flit,
  output port_t                    out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DX_MSB = dest_x_msb(DATA_W);
  localparam int DY_MSB = dest_y_msb(DATA_W, COORD_W);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    port_t             sel;
    logic [DATA_W-1:0] flit;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  port_t           in_sel;
  logic            empty;
  logic            push;
  logic            pop;
  logic            wr_en;
  logic            bypass;

  xy_route_compute #(
    .COORD_W  (COORD_W),
    .MESH_DIM (MESH_DIM)
  ) u_route (
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .dest_x (in_flit[DX_MSB -: COORD_W]),
    .dest_y (in_flit[DY_MSB -: COORD_W]),
    .port   (in_sel)
  );

  assign empty     = (count == '0);
  assign in_ready  = (count < FULL_CNT);
  assign occupancy = count;

`ifdef ROUTE_INPUT_BUFFER_BYPASS_EN
  // An empty buffer with a ready consumer hands the flit straight through.
  assign bypass    = empty && in_valid && out_ready;
  assign out_valid = !empty || bypass;
  assign out_flit  = bypass ? in_flit : mem[rd_ptr].flit;
  assign out_sel   = bypass ? in_sel  : mem[rd_ptr].sel;
`else
  assign bypass    = 1'b0;
  assign out_valid = !empty;
  assign out_flit  = mem[rd_ptr].flit;
  assign out_sel   = mem[rd_ptr].sel;
`endif

  assign push  = in_valid && in_ready;
  assign pop   = out_ready && !empty;
  assign wr_en = push && !bypass;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= '{sel: in_sel, flit: in_flit};
  end

endmodule

// File: tb/tb_route_input_buffer.sv
// Directed bench for route_input_buffer with a second instance on a 3x3 mesh
// for out-of-mesh routing; honours ROUTE_INPUT_BUFFER_BYPASS_EN if defined.
module tb_route_input_buffer;

  logic        clk;
  logic        reset;
  logic [1:0]  cur_x, cur_y;
  logic [31:0] in_flit, out_flit;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  out_sel, occupancy;

  logic [31:0] in_flit3, out_flit3;
  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [2:0]  out_sel3, occupancy3;

  int n_vec = 0;
  int n_err = 0;

  route_input_buffer #(.DATA_W(32), .DEPTH(4), .COORD_W(2), .MESH_DIM(4)) u_dut (
    .clk(clk), .reset(reset), .cur_x(cur_x), .cur_y(cur_y),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  route_input_buffer #(.DATA_W(32), .DEPTH(4), .COORD_W(2), .MESH_DIM(3)) u_dut3 (
    .clk(clk), .reset(reset), .cur_x(cur_x), .cur_y(cur_y),
    .in_flit(in_flit3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_flit(out_flit3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .occupancy(occupancy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] mk(input int dx, input int dy, input int pl);
    logic [1:0]  x2, y2;
    logic [27:0] p28;
    x2  = dx[1:0];
    y2  = dy[1:0];
    p28 = pl[27:0];
    return {x2, y2, p28};
  endfunction

  function automatic logic [2:0] ref_route(input int dx, input int dy, input int cx,
                                           input int cy, input int md);
    if (dx >= md || dy >= md) return 3'd5;
    if (dx > cx) return 3'd2;
    if (dx < cx) return 3'd4;
    if (dy > cy) return 3'd3;
    if (dy < cy) return 3'd1;
    return 3'd0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] f;
  logic [31:0] fill [4];
  logic [31:0] q  [$];
  logic [2:0]  qs [$];

  initial begin
    int tx [5] = '{3, 0, 1, 1, 1};
    int ty [5] = '{1, 1, 3, 0, 1};
    int es [5] = '{2, 4, 3, 1, 0};
    int ex3 [3] = '{3, 0, 2};
    int ey3 [3] = '{1, 3, 2};
    int es3 [3] = '{5, 5, 2};
    logic [31:0] g3 [3];
    int pushed, cyc, dx, dy;
    logic exp_rdy, bp;

    reset = 1'b1; cur_x = 2'd1; cur_y = 2'd1;
    in_flit = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_flit3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    step(); step();
    reset = 1'b0;
    settle();
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));

    // XY routing, one flit at a time through an always-ready consumer
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f = mk(tx[i], ty[i], 'h100 + i);
      in_flit = f; in_valid = 1'b1;
      settle();
      chk("xy_in_ready", 64'(in_ready), 64'(1));
`ifdef ROUTE_INPUT_BUFFER_BYPASS_EN
      chk("xy_bp_valid", 64'(out_valid), 64'(1));
      chk("xy_bp_sel",   64'(out_sel),   64'(es[i]));
      chk("xy_bp_flit",  64'(out_flit),  64'(f));
      step();
      in_valid = 1'b0;
      settle();
      chk("xy_bp_occ", 64'(occupancy), 64'(0));
`else
      chk("xy_pre_valid", 64'(out_valid), 64'(0));
      step();
      in_valid = 1'b0;
      settle();
      chk("xy_valid", 64'(out_valid), 64'(1));
      chk("xy_sel",   64'(out_sel),   64'(es[i]));
      chk("xy_flit",  64'(out_flit),  64'(f));
      step();
      settle();
      chk("xy_drained", 64'(out_valid), 64'(0));
`endif
    end

    // Fill to capacity with a stalled consumer; fifth flit must be refused
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f = mk(2, 1, 'h300 + i);
      if (i < 4) fill[i] = f;
      in_flit = f; in_valid = 1'b1;
      settle();
      chk("full_in_ready", 64'(in_ready), 64'(i < 4));
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("full_occ",      64'(occupancy), 64'(4));
    chk("full_in_ready", 64'(in_ready),  64'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("full_out_valid", 64'(out_valid), 64'(1));
      chk("full_out_flit",  64'(out_flit),  64'(fill[i]));
      chk("full_out_sel",   64'(out_sel),   64'(2));
      step();
    end
    settle();
    chk("full_empty", 64'(out_valid), 64'(0));

    // Push and pop together while full: push refused, slot opens next cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fill[i] = mk(0, 0, 'h400 + i);
      in_flit = fill[i]; in_valid = 1'b1;
      step();
    end
    f = mk(1, 0, 'h4ff);
    in_flit = f; in_valid = 1'b1; out_ready = 1'b1;
    settle();
    chk("pp_in_ready_full", 64'(in_ready), 64'(0));
    step();
    out_ready = 1'b0;
    settle();
    chk("pp_occ3",    64'(occupancy), 64'(3));
    chk("pp_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    settle();
    chk("pp_occ4", 64'(occupancy), 64'(4));
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      settle();
      chk("pp_drain_flit", 64'(out_flit), 64'(fill[i]));
      step();
    end
    settle();
    chk("pp_last_flit", 64'(out_flit), 64'(f));
    chk("pp_last_sel",  64'(out_sel),  64'(1));
    step();
    settle();
    chk("pp_empty", 64'(out_valid), 64'(0));

    // Out-of-mesh destinations on the 3x3 instance, head held under stall
    for (int i = 0; i < 3; i++) begin
      g3[i] = mk(ex3[i], ey3[i], 'h500 + i);
      in_flit3 = g3[i]; in_valid3 = 1'b1;
      step();
    end
    in_valid3 = 1'b0;
    settle();
    chk("mesh_occ", 64'(occupancy3), 64'(3));
    for (int c = 0; c < 3; c++) begin
      chk("mesh_hold_sel",  64'(out_sel3),  64'(es3[0]));
      chk("mesh_hold_flit", 64'(out_flit3), 64'(g3[0]));
      step();
      settle();
    end
    out_ready3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mesh_sel",  64'(out_sel3),  64'(es3[i]));
      chk("mesh_flit", 64'(out_flit3), 64'(g3[i]));
      step();
      settle();
    end
    chk("mesh_empty", 64'(out_valid3), 64'(0));
    out_ready3 = 1'b0;

    // Reset mid-operation with a coincident push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_flit = mk(3, 3, 'h600 + i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("mr_occ3", 64'(occupancy), 64'(3));
    reset = 1'b1; in_valid = 1'b1; in_flit = mk(0, 0, 'h6ff);
    step();
    reset = 1'b0; in_valid = 1'b0;
    settle();
    chk("mr_occ",       64'(occupancy), 64'(0));
    chk("mr_out_valid", 64'(out_valid), 64'(0));
    chk("mr_in_ready",  64'(in_ready),  64'(1));
    step(); step();
    settle();
    chk("mr_no_stale", 64'(out_valid), 64'(0));
    f = mk(1, 2, 'h6aa);
    in_flit = f; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    settle();
    chk("mr_new_flit", 64'(out_flit), 64'(f));
    chk("mr_new_sel",  64'(out_sel),  64'(3));
    chk("mr_new_occ",  64'(occupancy), 64'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Random throttle on both sides against a queue scoreboard
    pushed = 0; cyc = 0;
    while ((pushed < 20 || q.size() != 0) && cyc < 400) begin
      cyc++;
      dx = $urandom_range(0, 3);
      dy = $urandom_range(0, 3);
      f = mk(dx, dy, 'h700 + pushed);
      in_flit   = f;
      in_valid  = (pushed < 20) && ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      settle();
      exp_rdy = (q.size() < 4);
      bp = 1'b0;
`ifdef ROUTE_INPUT_BUFFER_BYPASS_EN
      bp = (q.size() == 0) && in_valid && out_ready;
`endif
      chk("rnd_in_ready",  64'(in_ready),  64'(exp_rdy));
      chk("rnd_occ",       64'(occupancy), 64'(q.size()));
      chk("rnd_out_valid", 64'(out_valid), 64'((q.size() != 0) || bp));
      if (bp) begin
        chk("rnd_bp_flit", 64'(out_flit), 64'(f));
        chk("rnd_bp_sel",  64'(out_sel),  64'(ref_route(dx, dy, 1, 1, 4)));
        pushed++;
      end else begin
        if (q.size() != 0 && out_ready) begin
          chk("rnd_flit", 64'(out_flit), 64'(q[0]));
          chk("rnd_sel",  64'(out_sel),  64'(qs[0]));
          void'(q.pop_front());
          void'(qs.pop_front());
        end
        if (in_valid && exp_rdy) begin
          q.push_back(f);
          qs.push_back(ref_route(dx, dy, 1, 1, 4));
          pushed++;
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    settle();
    chk("rnd_done", 64'((pushed == 20) && (q.size() == 0)), 64'(1));
    chk("rnd_final_occ", 64'(occupancy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
